// File: rtl/fastica_pkg.sv
// Shared definitions for the FastICA matrix datapath: matrix word format,
// default pass-counter width and the MUL2 sequencer state encoding.
package fastica_pkg;

  // Q13 matrix element format shared by MUL2 and its operand registers
  localparam int MAT_W      = 26;
  localparam int FRAC_W     = 13;

  // Default width of the squaring-pass counter
  localparam int ITER_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_FEED,
    ST_COPY,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/mul2_seq_ctrl.sv
// MUL2 squaring sequencer: loads external operands, then runs num_pass
// back-to-back squaring passes through MUL2 with result feedback, giving
// M^(2^N). Drives control strobes only; all outputs are registered.
module mul2_seq_ctrl
  import fastica_pkg::*;
#(
  parameter int ITER_W  = ITER_W_DEF,
  parameter int MUL_LAT = 1
) (
  input  logic              clk_mul,
  input  logic              rst_mul,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] num_pass,
  output logic              ready,
  output logic              busy,
  output logic              ld_op,
  output logic              sel_fb,
  output logic              en_mul,
  output logic              res_valid,
  output logic [ITER_W-1:0] pass_cnt,
  output logic              aborted
);

  localparam int LAT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  seq_state_e        state, state_nxt;
  logic [ITER_W-1:0] n_reg, n_nxt;
  logic [ITER_W-1:0] pass_nxt, pass_inc;
  logic [LAT_W-1:0]  lat_cnt, lat_nxt;
  logic              lat_last;
  logic              abort_nxt;

  assign pass_inc = pass_cnt + 1'b1;
  assign lat_last = (lat_cnt == LAT_W'(MUL_LAT - 1));

  // Next-state, counter and abort-acknowledge decision for the sequencer
  always_comb begin
    state_nxt = state;
    n_nxt     = n_reg;
    pass_nxt  = pass_cnt;
    lat_nxt   = lat_cnt;
    abort_nxt = 1'b0;
    if ((state != ST_IDLE) && abort) begin
      // Abort freezes pass_cnt and returns to IDLE from any busy state
      state_nxt = ST_IDLE;
      lat_nxt   = '0;
      abort_nxt = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            n_nxt     = num_pass;
            pass_nxt  = '0;
            state_nxt = ST_LOAD;
          end
        end
        ST_LOAD: state_nxt = (n_reg != '0) ? ST_ISSUE : ST_COPY;
        ST_ISSUE: begin
          if (lat_last) begin
            lat_nxt   = '0;
            pass_nxt  = pass_inc;
            state_nxt = (pass_inc == n_reg) ? ST_DONE : ST_FEED;
          end else begin
            lat_nxt = lat_cnt + 1'b1;
          end
        end
        ST_FEED: state_nxt = ST_ISSUE;
        ST_COPY: begin
          // MUL2 with en_mul low passes operands through in MUL_LAT cycles
          if (lat_last) begin
            lat_nxt   = '0;
            state_nxt = ST_DONE;
          end else begin
            lat_nxt = lat_cnt + 1'b1;
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State/counter registers; Moore outputs registered from the next state
  always_ff @(posedge clk_mul) begin
    if (rst_mul) begin
      state     <= ST_IDLE;
      n_reg     <= '0;
      pass_cnt  <= '0;
      lat_cnt   <= '0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      ld_op     <= 1'b0;
      sel_fb    <= 1'b0;
      en_mul    <= 1'b0;
      res_valid <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_nxt;
      n_reg     <= n_nxt;
      pass_cnt  <= pass_nxt;
      lat_cnt   <= lat_nxt;
      ready     <= (state_nxt == ST_IDLE);
      busy      <= (state_nxt != ST_IDLE);
      ld_op     <= (state_nxt == ST_LOAD) || (state_nxt == ST_FEED);
      sel_fb    <= (state_nxt == ST_FEED);
      en_mul    <= (state_nxt == ST_ISSUE);
      res_valid <= (state_nxt == ST_DONE);
      aborted   <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_mul2_seq_ctrl.sv
// Directed bench for mul2_seq_ctrl: one MUL_LAT=1 instance driving a scalar
// MUL2/operand-register model (diagonal element), plus a MUL_LAT=2 instance.
module tb_mul2_seq_ctrl;
  import fastica_pkg::*;

  localparam int IW = 4;

  // Output code order: {ready,busy,ld_op,sel_fb,en_mul,res_valid,aborted}
  localparam logic [6:0] O_IDLE  = 7'b1000000;
  localparam logic [6:0] O_LOAD  = 7'b0110000;
  localparam logic [6:0] O_ISSUE = 7'b0100100;
  localparam logic [6:0] O_FEED  = 7'b0111000;
  localparam logic [6:0] O_COPY  = 7'b0100000;
  localparam logic [6:0] O_DONE  = 7'b0100010;
  localparam logic [6:0] O_ABORT = 7'b1000001;

  logic clk_mul = 1'b0;
  logic rst_mul = 1'b1;

  logic          a_start = 1'b0, a_abort = 1'b0;
  logic [IW-1:0] a_np = '0;
  logic          a_ready, a_busy, a_ld_op, a_sel_fb, a_en_mul, a_res_valid, a_aborted;
  logic [IW-1:0] a_pass_cnt;
  logic [6:0]    a_outs;

  logic          b_start = 1'b0, b_abort = 1'b0;
  logic [IW-1:0] b_np = '0;
  logic          b_ready, b_busy, b_ld_op, b_sel_fb, b_en_mul, b_res_valid, b_aborted;
  logic [IW-1:0] b_pass_cnt;
  logic [6:0]    b_outs;

  int nchk  = 0;
  int nfail = 0;

  always #5 clk_mul = ~clk_mul;

  mul2_seq_ctrl #(.ITER_W(IW), .MUL_LAT(1)) dut_a (
    .clk_mul(clk_mul), .rst_mul(rst_mul), .start(a_start), .abort(a_abort),
    .num_pass(a_np), .ready(a_ready), .busy(a_busy), .ld_op(a_ld_op),
    .sel_fb(a_sel_fb), .en_mul(a_en_mul), .res_valid(a_res_valid),
    .pass_cnt(a_pass_cnt), .aborted(a_aborted)
  );

  mul2_seq_ctrl #(.ITER_W(IW), .MUL_LAT(2)) dut_b (
    .clk_mul(clk_mul), .rst_mul(rst_mul), .start(b_start), .abort(b_abort),
    .num_pass(b_np), .ready(b_ready), .busy(b_busy), .ld_op(b_ld_op),
    .sel_fb(b_sel_fb), .en_mul(b_en_mul), .res_valid(b_res_valid),
    .pass_cnt(b_pass_cnt), .aborted(b_aborted)
  );

  assign a_outs = {a_ready, a_busy, a_ld_op, a_sel_fb, a_en_mul, a_res_valid, a_aborted};
  assign b_outs = {b_ready, b_busy, b_ld_op, b_sel_fb, b_en_mul, b_res_valid, b_aborted};

  // Scalar model of one diagonal element: operand register + MUL2 (1 stage)
  logic signed [MAT_W-1:0]   ext_m = '0;
  logic signed [MAT_W-1:0]   op_m  = '0;
  logic signed [MAT_W-1:0]   o_m   = '0;
  logic signed [2*MAT_W-1:0] prod_m;
  assign prod_m = op_m * op_m;

  always_ff @(posedge clk_mul) begin
    if (a_ld_op) op_m <= a_sel_fb ? o_m : ext_m;
    if (a_en_mul) o_m <= prod_m[MAT_W+FRAC_W-1:FRAC_W];
    else          o_m <= op_m;
  end

  task automatic tick();
    @(posedge clk_mul);
    @(negedge clk_mul);
  endtask

  task automatic test_reset();
    rst_mul = 1'b1;
    tick(); tick();
    nchk++;
    if (a_outs !== O_IDLE) begin nfail++; $display("FAIL reset_outs got=%b want=%b", a_outs, O_IDLE); end
    nchk++;
    if (a_pass_cnt !== 4'd0) begin nfail++; $display("FAIL reset_pass_cnt got=%0d want=0", a_pass_cnt); end
    nchk++;
    if (b_outs !== O_IDLE) begin nfail++; $display("FAIL reset_outs_b got=%b want=%b", b_outs, O_IDLE); end
    rst_mul = 1'b0;
    // start together with abort in IDLE is ignored; abort alone does nothing
    a_start = 1'b1; a_abort = 1'b1; a_np = 4'd2;
    tick();
    a_start = 1'b0;
    nchk++;
    if (a_outs !== O_IDLE) begin nfail++; $display("FAIL idle_start_abort got=%b want=%b", a_outs, O_IDLE); end
    tick();
    a_abort = 1'b0;
    nchk++;
    if (a_outs !== O_IDLE) begin nfail++; $display("FAIL idle_abort got=%b want=%b", a_outs, O_IDLE); end
  endtask

  task automatic test_three_pass();
    logic [6:0] exp_tab [8];
    exp_tab = '{O_LOAD, O_ISSUE, O_FEED, O_ISSUE, O_FEED, O_ISSUE, O_DONE, O_IDLE};
    ext_m = 26'sd16384;
    a_np = 4'd3; a_start = 1'b1;
    tick();
    a_start = 1'b0; a_np = 4'd9;
    for (int k = 1; k <= 8; k++) begin
      nchk++;
      if (a_outs !== exp_tab[k-1]) begin
        nfail++; $display("FAIL three_pass_outs S+%0d got=%b want=%b", k, a_outs, exp_tab[k-1]);
      end
      if (k == 7) begin
        nchk++;
        if (o_m !== 26'sd2097152) begin nfail++; $display("FAIL three_pass_result got=%0d want=2097152", o_m); end
        nchk++;
        if (a_pass_cnt !== 4'd3) begin nfail++; $display("FAIL three_pass_cnt got=%0d want=3", a_pass_cnt); end
      end
      if (k < 8) tick();
    end
    nchk++;
    if (a_pass_cnt !== 4'd3) begin nfail++; $display("FAIL three_pass_cnt_hold got=%0d want=3", a_pass_cnt); end
  endtask

  task automatic test_zero_pass();
    logic [6:0] exp_tab [4];
    exp_tab = '{O_LOAD, O_COPY, O_DONE, O_IDLE};
    ext_m = -26'sd12345;
    a_np = 4'd0; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      nchk++;
      if (a_outs !== exp_tab[k-1]) begin
        nfail++; $display("FAIL zero_pass_outs S+%0d got=%b want=%b", k, a_outs, exp_tab[k-1]);
      end
      if (k == 3) begin
        nchk++;
        if (o_m !== -26'sd12345) begin nfail++; $display("FAIL zero_pass_result got=%0d want=-12345", o_m); end
        nchk++;
        if (a_pass_cnt !== 4'd0) begin nfail++; $display("FAIL zero_pass_cnt got=%0d want=0", a_pass_cnt); end
      end
      if (k < 4) tick();
    end
  endtask

  task automatic test_abort();
    bit done;
    a_np = 4'd2; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick(); tick();
    nchk++;
    if (a_outs !== O_FEED) begin nfail++; $display("FAIL abort_pre_feed got=%b want=%b", a_outs, O_FEED); end
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    nchk++;
    if (a_outs !== O_ABORT) begin nfail++; $display("FAIL abort_ack got=%b want=%b", a_outs, O_ABORT); end
    nchk++;
    if (a_pass_cnt !== 4'd1) begin nfail++; $display("FAIL abort_pass_cnt got=%0d want=1", a_pass_cnt); end
    a_np = 4'd0; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    nchk++;
    if (a_outs !== O_LOAD) begin nfail++; $display("FAIL abort_restart got=%b want=%b", a_outs, O_LOAD); end
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      tick();
      if (a_ready === 1'b1) done = 1'b1;
    end
    nchk++;
    if (!done) begin nfail++; $display("FAIL abort_drain got=busy want=idle"); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_o;
    a_np = 4'd1; a_start = 1'b1;
    for (int c = 0; c < 12; c++) begin
      case (c % 4)
        0: exp_o = O_IDLE;
        1: exp_o = O_LOAD;
        2: exp_o = O_ISSUE;
        default: exp_o = O_DONE;
      endcase
      nchk++;
      if (a_outs !== exp_o) begin nfail++; $display("FAIL b2b_outs c%0d got=%b want=%b", c, a_outs, exp_o); end
      tick();
    end
    a_start = 1'b0;
    nchk++;
    if (a_pass_cnt !== 4'd1) begin nfail++; $display("FAIL b2b_pass_cnt got=%0d want=1", a_pass_cnt); end
    tick();
    nchk++;
    if (a_outs !== O_IDLE) begin nfail++; $display("FAIL b2b_end got=%b want=%b", a_outs, O_IDLE); end
  endtask

  task automatic test_lat2();
    logic [6:0] exp_tab [8];
    exp_tab = '{O_LOAD, O_ISSUE, O_ISSUE, O_FEED, O_ISSUE, O_ISSUE, O_DONE, O_IDLE};
    b_np = 4'd2; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      nchk++;
      if (b_outs !== exp_tab[k-1]) begin
        nfail++; $display("FAIL lat2_outs S+%0d got=%b want=%b", k, b_outs, exp_tab[k-1]);
      end
      if (k == 7) begin
        nchk++;
        if (b_pass_cnt !== 4'd2) begin nfail++; $display("FAIL lat2_pass_cnt got=%0d want=2", b_pass_cnt); end
      end
      if (k < 8) tick();
    end
  endtask

  task automatic test_reset_mid_job();
    a_np = 4'd3; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    nchk++;
    if (a_outs !== O_ISSUE) begin nfail++; $display("FAIL rstmid_pre got=%b want=%b", a_outs, O_ISSUE); end
    rst_mul = 1'b1;
    tick();
    rst_mul = 1'b0;
    nchk++;
    if (a_outs !== O_IDLE) begin nfail++; $display("FAIL rstmid_outs got=%b want=%b", a_outs, O_IDLE); end
    nchk++;
    if (a_pass_cnt !== 4'd0) begin nfail++; $display("FAIL rstmid_pass_cnt got=%0d want=0", a_pass_cnt); end
    for (int k = 0; k < 4; k++) begin
      tick();
      nchk++;
      if (a_outs !== O_IDLE) begin nfail++; $display("FAIL rstmid_quiet c%0d got=%b want=%b", k, a_outs, O_IDLE); end
    end
  endtask

  initial begin
    @(negedge clk_mul);
    test_reset();
    test_three_pass();
    test_zero_pass();
    test_abort();
    test_back_to_back();
    test_lat2();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
